// File: rtl/alu_operand_loader.sv
// Byte-serial front end for the 16-bit ALU: gathers a 4-byte framed stream into
// operands A/B, holds them until consumed, and resynchronises after malformed frames.
module alu_operand_loader #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [7:0]       in_byte,
    input  logic             in_valid,
    input  logic             in_last,
    output logic             in_ready,
    output logic [WIDTH-1:0] op_a,
    output logic [WIDTH-1:0] op_b,
    output logic             op_valid,
    input  logic             op_ready,
    output logic             frame_err,
    output logic [7:0]       frame_cnt
);

    typedef enum logic [1:0] {
        ST_LOAD    = 2'd0,
        ST_PRESENT = 2'd1,
        ST_DRAIN   = 2'd2
    } state_t;

    state_t          state_q;
    logic [1:0]      idx_q;
    logic            frame_err_q;
    logic [7:0]      frame_cnt_q;
    logic [3:0][7:0] slot_bytes;

    logic accept;
    logic load_wr;
    logic load_clr;

    assign in_ready = !rst && (state_q != ST_PRESENT);
    assign accept   = in_valid && in_ready;

    // A frame is malformed exactly when in_last disagrees with "this is slot 3".
    always_comb begin
        load_wr  = 1'b0;
        load_clr = 1'b0;
        if (accept && (state_q == ST_LOAD)) begin
            if (in_last != (idx_q == 2'd3)) begin
                load_clr = 1'b1;
            end else begin
                load_wr = 1'b1;
            end
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_slot
            logic [7:0] byte_q;

            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    byte_q <= 8'h00;
                end else if (load_clr) begin
                    byte_q <= 8'h00;
                end else if (load_wr && (idx_q == 2'(gi))) begin
                    byte_q <= in_byte;
                end
            end

            assign slot_bytes[gi] = byte_q;
        end
    endgenerate

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_LOAD;
            idx_q       <= 2'd0;
            frame_err_q <= 1'b0;
            frame_cnt_q <= 8'd0;
        end else begin
            frame_err_q <= 1'b0;
            case (state_q)
                ST_LOAD: begin
                    if (load_clr) begin
                        frame_err_q <= 1'b1;
                        idx_q       <= 2'd0;
                        // Short frames end here; long frames still have bytes to discard.
                        state_q     <= in_last ? ST_LOAD : ST_DRAIN;
                    end else if (load_wr) begin
                        idx_q <= idx_q + 2'd1;
                        if (in_last) begin
                            state_q <= ST_PRESENT;
                        end
                    end
                end
                ST_PRESENT: begin
                    if (op_ready) begin
                        state_q     <= ST_LOAD;
                        idx_q       <= 2'd0;
                        frame_cnt_q <= frame_cnt_q + 8'd1;
                    end
                end
                ST_DRAIN: begin
                    if (accept && in_last) begin
                        state_q <= ST_LOAD;
                        idx_q   <= 2'd0;
                    end
                end
                default: begin
                    state_q <= ST_LOAD;
                    idx_q   <= 2'd0;
                end
            endcase
        end
    end

    assign op_a      = {slot_bytes[1], slot_bytes[0]};
    assign op_b      = {slot_bytes[3], slot_bytes[2]};
    assign op_valid  = (state_q == ST_PRESENT);
    assign frame_err = frame_err_q;
    assign frame_cnt = frame_cnt_q;

endmodule

// File: tb/tb_alu_operand_loader.sv
// Bench for alu_operand_loader: directed frame table, reset cases, back-to-back
// throughput, and randomized frames checked against a frame-level reference model.
module tb_alu_operand_loader;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [7:0]  in_byte = 8'h00;
    logic        in_valid = 1'b0;
    logic        in_last = 1'b0;
    logic        in_ready;
    logic [15:0] op_a;
    logic [15:0] op_b;
    logic        op_valid;
    logic        op_ready = 1'b0;
    logic        frame_err;
    logic [7:0]  frame_cnt;

    int n_vec = 0;
    int n_bad = 0;
    int cyc = 0;
    int last_v_cyc = -1;
    bit rand_rdy = 1'b0;
    bit rand_gap = 1'b0;
    bit tput = 1'b0;

    // Reference model: pairs of good frames awaiting consumption, pairs consumed, errors expected.
    logic [31:0] exp_q[$];
    int mdl_cnt = 0;
    int err_seen = 0;
    int exp_err = 0;

    typedef struct packed {
        logic [5:0][7:0] bytes;
        logic [2:0]      len;
        logic [15:0]     a;
        logic [15:0]     b;
        logic            valid;
        logic            err;
    } vec_t;

    vec_t tbl[9];

    alu_operand_loader #(.WIDTH(16)) dut (
        .clk(clk),
        .rst(rst),
        .in_byte(in_byte),
        .in_valid(in_valid),
        .in_last(in_last),
        .in_ready(in_ready),
        .op_a(op_a),
        .op_b(op_b),
        .op_valid(op_valid),
        .op_ready(op_ready),
        .frame_err(frame_err),
        .frame_cnt(frame_cnt)
    );

    always #5 clk = ~clk;

    initial begin
        #800000;
        $display("FAIL watchdog: time limit reached, want completion");
        $fatal(1, "watchdog expired");
    end

    function automatic vec_t mk(input logic [7:0] b0, input logic [7:0] b1, input logic [7:0] b2,
                                input logic [7:0] b3, input logic [7:0] b4, input logic [7:0] b5,
                                input int len, input logic [15:0] a, input logic [15:0] b,
                                input logic v, input logic e);
        vec_t r;
        r.bytes[0] = b0; r.bytes[1] = b1; r.bytes[2] = b2;
        r.bytes[3] = b3; r.bytes[4] = b4; r.bytes[5] = b5;
        r.len = 3'(len);
        r.a = a;
        r.b = b;
        r.valid = v;
        r.err = e;
        return r;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        n_vec++;
        if (act !== req) begin
            n_bad++;
            $display("FAIL %s: got %h, want %h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    task automatic tick();
        bit pre_v;
        bit pre_r;
        if (rand_rdy) op_ready = ($urandom_range(0, 3) != 0);
        if (!in_valid) begin
            in_last = 1'($urandom_range(0, 1));
            in_byte = 8'($urandom);
        end
        pre_v = op_valid;
        pre_r = op_ready;
        @(posedge clk);
        #1;
        cyc++;
        if (pre_v && pre_r) begin
            mdl_cnt++;
            if (exp_q.size() > 0) void'(exp_q.pop_front());
        end
        chk("frame_cnt", 32'(frame_cnt), 32'(mdl_cnt % 256));
        if (!rst) chk("in_ready_vs_op_valid", 32'(in_ready), 32'(!op_valid));
        if (frame_err === 1'b1) err_seen++;
        if (op_valid === 1'b1) begin
            if (exp_q.size() == 0) begin
                n_vec++;
                n_bad++;
                $display("FAIL op_valid_unexpected: got op_valid=1, want 0 (cycle %0d)", cyc);
            end else begin
                chk("op_pair", {op_a, op_b}, exp_q[0]);
            end
            if (tput) begin
                if (last_v_cyc >= 0) chk("valid_period", 32'(cyc - last_v_cyc), 32'd5);
                last_v_cyc = cyc;
            end
        end
    endtask

    task automatic send_byte(input logic [7:0] b, input bit last, output bit err_after);
        int guard;
        guard = 0;
        if (rand_gap) repeat ($urandom_range(0, 2)) tick();
        in_valid = 1'b1;
        in_byte  = b;
        in_last  = last;
        while (!in_ready && guard < 200) begin
            tick();
            guard++;
        end
        if (!in_ready) begin
            n_vec++;
            n_bad++;
            $display("FAIL in_ready_timeout: got in_ready=0 for 200 cycles, want 1");
        end
        tick();
        err_after = frame_err;
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    // Good frames are exactly 4 bytes; short frames flag their last byte, long ones the 4th.
    task automatic send_frame(input logic [5:0][7:0] b, input int len);
        int err_idx;
        bit e;
        err_idx = (len < 4) ? len - 1 : ((len > 4) ? 3 : -1);
        if (len == 4) exp_q.push_back({b[1], b[0], b[3], b[2]});
        else exp_err++;
        for (int i = 0; i < len; i++) begin
            send_byte(b[i], (i == len - 1), e);
            chk($sformatf("frame_err_byte%0d", i), 32'(e), 32'(i == err_idx));
        end
    endtask

    task automatic reset_async_check(input string tag);
        #2;
        rst = 1'b1;
        #1;
        exp_q.delete();
        mdl_cnt = 0;
        chk({tag, "_in_ready"}, 32'(in_ready), 32'd0);
        chk({tag, "_op_valid"}, 32'(op_valid), 32'd0);
        chk({tag, "_ops"}, {op_a, op_b}, 32'd0);
        chk({tag, "_frame_err"}, 32'(frame_err), 32'd0);
        chk({tag, "_frame_cnt"}, 32'(frame_cnt), 32'd0);
        @(posedge clk);
        #1;
        chk({tag, "_in_ready_held"}, 32'(in_ready), 32'd0);
        rst = 1'b0;
    endtask

    initial begin
        logic [7:0] cnt0;
        logic [5:0][7:0] rb;
        int errs0;
        int hold;
        int r;
        int len;
        bit e;

        tbl[0] = mk(8'hDB, 8'h48, 8'h68, 8'h51, 8'h00, 8'h00, 4, 16'h48DB, 16'h5168, 1'b1, 1'b0);
        tbl[1] = mk(8'h11, 8'h22, 8'h33, 8'h00, 8'h00, 8'h00, 3, 16'h0000, 16'h0000, 1'b0, 1'b1);
        tbl[2] = mk(8'h52, 8'h14, 8'h45, 8'h7A, 8'h00, 8'h00, 4, 16'h1452, 16'h7A45, 1'b1, 1'b0);
        tbl[3] = mk(8'hA1, 8'hB2, 8'hC3, 8'hD4, 8'hE5, 8'hF6, 6, 16'h0000, 16'h0000, 1'b0, 1'b1);
        tbl[4] = mk(8'h01, 8'h80, 8'hFF, 8'h00, 8'h00, 8'h00, 4, 16'h8001, 16'h00FF, 1'b1, 1'b0);
        tbl[5] = mk(8'h77, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 1, 16'h0000, 16'h0000, 1'b0, 1'b1);
        tbl[6] = mk(8'h99, 8'h88, 8'h00, 8'h00, 8'h00, 8'h00, 2, 16'h0000, 16'h0000, 1'b0, 1'b1);
        tbl[7] = mk(8'hAA, 8'h55, 8'h5A, 8'hA5, 8'h00, 8'h00, 4, 16'h55AA, 16'hA55A, 1'b1, 1'b0);
        tbl[8] = mk(8'h10, 8'h20, 8'h30, 8'h40, 8'h50, 8'h00, 5, 16'h0000, 16'h0000, 1'b0, 1'b1);

        // Power-on reset.
        #1;
        rst = 1'b1;
        #1;
        chk("rst_in_ready", 32'(in_ready), 32'd0);
        chk("rst_op_valid", 32'(op_valid), 32'd0);
        chk("rst_ops", {op_a, op_b}, 32'd0);
        chk("rst_frame_err", 32'(frame_err), 32'd0);
        chk("rst_frame_cnt", 32'(frame_cnt), 32'd0);
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        tick();

        // Directed frame table, with backpressure on every good frame.
        for (int i = 0; i < 9; i++) begin
            op_ready = 1'b0;
            errs0 = err_seen;
            send_frame(tbl[i].bytes, int'(tbl[i].len));
            chk($sformatf("tbl%0d_op_valid", i), 32'(op_valid), 32'(tbl[i].valid));
            chk($sformatf("tbl%0d_ops", i), {op_a, op_b}, {tbl[i].a, tbl[i].b});
            chk($sformatf("tbl%0d_err_pulses", i), 32'(err_seen - errs0), 32'(tbl[i].err));
            if (i == 0) chk("xor_unit", 32'(op_a ^ op_b), 32'h19B3);
            if (tbl[i].valid) begin
                hold = (i == 0) ? 10 : 2;
                in_valid = 1'b1;
                in_byte  = 8'hEE;
                in_last  = 1'b0;
                repeat (hold) begin
                    tick();
                    chk($sformatf("tbl%0d_stall_in_ready", i), 32'(in_ready), 32'd0);
                    chk($sformatf("tbl%0d_stall_ops", i), {op_a, op_b}, {tbl[i].a, tbl[i].b});
                end
                in_valid = 1'b0;
                op_ready = 1'b1;
                cnt0 = frame_cnt;
                tick();
                op_ready = 1'b0;
                chk($sformatf("tbl%0d_op_valid_fall", i), 32'(op_valid), 32'd0);
                chk($sformatf("tbl%0d_in_ready_rise", i), 32'(in_ready), 32'd1);
                chk($sformatf("tbl%0d_frame_cnt_inc", i), 32'(frame_cnt), 32'(8'(cnt0 + 8'd1)));
                chk($sformatf("tbl%0d_ops_kept", i), {op_a, op_b}, {tbl[i].a, tbl[i].b});
            end
        end

        // Reset after two bytes of a frame.
        send_byte(8'h12, 1'b0, e);
        send_byte(8'h34, 1'b0, e);
        reset_async_check("rst_midframe");
        tick();
        send_frame(tbl[2].bytes, 4);
        chk("post_rst1_ops", {op_a, op_b}, {16'h1452, 16'h7A45});
        op_ready = 1'b1;
        tick();
        op_ready = 1'b0;
        chk("post_rst1_frame_cnt", 32'(frame_cnt), 32'd1);

        // Reset while a pair is presented and stalled.
        send_frame(tbl[7].bytes, 4);
        chk("pre_rst2_op_valid", 32'(op_valid), 32'd1);
        reset_async_check("rst_present");
        tick();
        send_frame(tbl[0].bytes, 4);
        chk("post_rst2_ops", {op_a, op_b}, {16'h48DB, 16'h5168});
        op_ready = 1'b1;
        tick();
        chk("post_rst2_frame_cnt", 32'(frame_cnt), 32'd1);

        // 256 back-to-back frames: one pair every 5 cycles, counter wraps to start.
        cnt0 = frame_cnt;
        op_ready = 1'b1;
        tput = 1'b1;
        last_v_cyc = -1;
        for (int f = 0; f < 256; f++) begin
            for (int k = 0; k < 6; k++) rb[k] = 8'($urandom);
            send_frame(rb, 4);
        end
        tick();
        tput = 1'b0;
        chk("wrap_frame_cnt", 32'(frame_cnt), 32'(cnt0));

        // Randomized frames with random gaps and backpressure.
        rand_rdy = 1'b1;
        rand_gap = 1'b1;
        for (int f = 0; f < 300; f++) begin
            r = $urandom_range(0, 9);
            len = (r < 5) ? 4 : (r == 5) ? 1 : (r == 6) ? 2 : (r == 7) ? 3 : (r == 8) ? 5 : 6;
            for (int k = 0; k < 6; k++) rb[k] = 8'($urandom);
            send_frame(rb, len);
        end
        rand_rdy = 1'b0;
        rand_gap = 1'b0;
        op_ready = 1'b1;
        repeat (3) tick();
        chk("rand_all_consumed", 32'(exp_q.size()), 32'd0);
        chk("total_err_pulses", 32'(err_seen), 32'(exp_err));

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule

// File: doc/alu_operand_loader.md
# alu_operand_loader

Byte-serial operand front end for the 16-bit ALU datapath. It accepts a framed stream of four bytes over a valid/ready handshake and assembles them into two 16-bit operands. It presents both operands, held stable, to the downstream bitwise units (XOR, AND, OR calculators) until they are consumed. It checks frame length and resynchronises after malformed frames.

## Interface
- WIDTH, 16, operand width in bits; fixed at 16 for this revision (2 bytes per operand, 4 bytes per frame)
- clk  input  1  single clock; all state changes on rising edge
- rst  input  1  asynchronous, active-high reset
- in_byte  input  8  operand byte
- in_valid  input  1  in_byte is valid this cycle
- in_last  input  1  marks final byte of a frame; qualified by in_valid
- in_ready  output  1  loader accepts a byte this cycle
- op_a  output  16  operand A (feeds in1 of the ALU units)
- op_b  output  16  operand B (feeds in2 of the ALU units)
- op_valid  output  1  op_a/op_b hold a complete frame
- op_ready  input  1  downstream consumes the operands
- frame_err  output  1  one-cycle pulse on a malformed frame
- frame_cnt  output  8  count of operand pairs consumed; wraps 255→0

## Operation
- **Byte acceptance:** a byte is accepted when in_valid && in_ready at a rising edge.
- **Frame order:** A[7:0], A[15:8], B[7:0], B[15:8]. in_last is set only on the 4th byte.
- **States:**
  - LOAD: in_ready=1. A 2-bit byte index idx starts at 0. Each accepted byte is written into its slot of op_a/op_b, selected by idx, and idx increments.
  - PRESENT: in_ready=0, op_valid=1. op_a/op_b are frozen.
  - DRAIN: in_ready=1. Bytes are discarded.
- **LOAD, idx=3, in_last=1:** → PRESENT.
- **LOAD, in_last=1 with idx<3 (short frame):**
  - frame_err pulses.
  - op_a and op_b are cleared to 0 and idx=0.
  - The state stays LOAD.
- **LOAD, idx=3, in_last=0 (long frame):**
  - frame_err pulses.
  - op_a and op_b are cleared to 0 and idx=0.
  - → DRAIN.
- **DRAIN:** bytes are discarded until a byte with in_last=1 is accepted, then → LOAD with idx=0. No additional frame_err is raised in DRAIN.
- **PRESENT:** when op_valid && op_ready at an edge:
  - → LOAD with idx=0.
  - frame_cnt increments.
  - op_a/op_b keep their value until overwritten byte by byte.
- **Stall:** op_ready low holds PRESENT indefinitely. in_ready stays 0, so upstream stalls.
- **in_last without in_valid:** ignored.
- **op_ready while op_valid=0:** ignored.
- **Reset:**
  - state=LOAD, idx=0, op_a=0, op_b=0, op_valid=0, frame_err=0, frame_cnt=0.
  - in_ready=0 while rst is high.
  - Reset mid-frame discards partial bytes. Reset in PRESENT drops the pending pair without a frame_cnt increment.

## Timing
- All outputs are registered or are decodes of registered state. in_ready and op_valid depend only on state and rst, never combinationally on in_valid or op_ready.
- **Latency:** op_valid rises on the edge that accepts the 4th byte; it is visible the cycle after acceptance.
- **Minimum frame period:** 5 cycles (4 accept cycles + 1 PRESENT cycle with op_ready=1).
- **op_valid fall:** op_valid falls on the consuming edge. in_ready rises in the same cycle (the first LOAD cycle).
- **frame_err:** high for exactly the cycle following the offending accept edge.
- **frame_cnt:** updates on the consuming edge; 8-bit unsigned, modulo 256.
- **Asynchronous reset:** reset takes effect without a clock edge. Release is sampled at the next rising edge.

## Test plan
- **Single frame:** bytes DB,48 / 68,51 with in_last on byte 4, op_ready=1 → op_a=16'h48DB, op_b=16'h5168, op_valid for 1 cycle, frame_cnt=1. The XOR unit output is 16'h19B3.
- **Backpressure:** hold op_ready=0 for 10 cycles after a frame, then offer the next frame bytes → in_ready=0, op_a/op_b unchanged throughout. The next frame is accepted only after op_ready=1.
- **Short frame:** 3 bytes with in_last on byte 3 → frame_err 1-cycle pulse, op_a=op_b=0, op_valid never rises. A following good frame 52,14 / 45,7A yields op_a=16'h1452, op_b=16'h7A45.
- **Long frame:** 6 bytes with in_last on byte 6 → frame_err exactly once, after byte 4. Bytes 5–6 are discarded; the next good frame is presented correctly.
- **Counter wrap / throughput:** 256 back-to-back frames with in_valid and op_ready tied high → op_valid every 5th cycle, frame_cnt returns to 0.
- **Reset mid-operation:** assert rst after byte 2, and separately while in PRESENT → all outputs at their reset values immediately. The next frame loads cleanly and frame_cnt has not counted the dropped pair.
